// File: rtl/layer_output_serializer.sv
// Collects one layer's parallel neuron outputs and streams them word-by-word into the
// next layer's serial input, with a one-vector pending buffer and a mandatory idle gap.
module layer_output_serializer #(
  parameter int NUM_NEURONS = 4,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_NEURONS-1:0]            in_valid_vec,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  output logic                              out_last,
  output logic                              busy,
  output logic                              overflow,
  output logic                              misalign
);

  localparam int CW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] shift_buf [NUM_NEURONS];
  logic [DATA_WIDTH-1:0] pend_buf  [NUM_NEURONS];
  logic                  pend_full;

  logic capture;
  logic partial;
  logic last_word;
  logic load_shift_in;
  logic load_shift_pend;
  logic load_pend;

  // A capture in GAP with nothing pending loads straight into the shift buffer, which
  // keeps the pending buffer empty whenever the FSM reaches IDLE.
  always_comb begin
    capture         = &in_valid_vec;
    partial         = (|in_valid_vec) && !capture;
    last_word       = (cnt == CW'(NUM_NEURONS - 1));
    load_shift_in   = capture && ((state == IDLE) || ((state == GAP) && !pend_full));
    load_shift_pend = (state == GAP) && pend_full;
    load_pend       = capture && (state == SHIFT) && !pend_full;
  end

  // NOTE: the word buffers carry no reset; they are only read while the control state
  // marks them valid, so clearing them would add reset fan-out for no behavioural gain.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (load_shift_in)
        shift_buf[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
      else if (load_shift_pend)
        shift_buf[i] <= pend_buf[i];
      if (load_pend)
        pend_buf[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pend_full <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      if (partial)
        misalign <= 1'b1;
      if (capture && (state != IDLE) && pend_full)
        overflow <= 1'b1;

      case (state)
        IDLE: begin
          out_data  <= '0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          cnt       <= '0;
          busy      <= capture;
          if (capture)
            state <= SHIFT;
        end

        SHIFT: begin
          out_data  <= shift_buf[cnt];
          out_valid <= 1'b1;
          out_last  <= last_word;
          busy      <= 1'b1;
          if (load_pend)
            pend_full <= 1'b1;
          if (last_word) begin
            cnt   <= '0;
            state <= GAP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        GAP: begin
          out_data  <= '0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          cnt       <= '0;
          busy      <= pend_full || capture;
          if (pend_full) begin
            pend_full <= 1'b0;
            state     <= SHIFT;
          end else if (capture) begin
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          out_data  <= '0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_output_serializer.sv
// Scoreboard bench: a vector-level model predicts each word and its edge, busy and the
// sticky flags; a negedge monitor compares every cycle against the DUT.
module tb_layer_output_serializer;

  localparam int NN = 4;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NN*DW-1:0]  in_data;
  logic [NN-1:0]     in_valid_vec;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_last;
  logic              busy;
  logic              overflow;
  logic              misalign;

  layer_output_serializer #(.NUM_NEURONS(NN), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid_vec (in_valid_vec),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .busy         (busy),
    .overflow     (overflow),
    .misalign     (misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            edge_n;
  } exp_t;

  // c = edge the vector was captured, l = edge it entered the shift buffer
  typedef struct {
    int c;
    int l;
  } rec_t;

  exp_t sb[$];
  rec_t recs[$];
  int   edge_cnt = 0;
  int   ovf_edge = -1;
  int   mis_edge = -1;
  int   n_cmp    = 0;
  int   n_fail   = 0;
  bit   check_en = 1'b0;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (after edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic logic exp_busy(input int e);
    foreach (recs[i])
      if (recs[i].c <= e && e <= recs[i].l + NN) return 1'b1;
    return 1'b0;
  endfunction

  // Model of one sampling edge t: a vector is accepted unless another one is waiting,
  // and it starts streaming once the previous vector plus its idle gap has gone by.
  task automatic model_edge(input int t, input logic [NN-1:0] vv, input logic [NN*DW-1:0] d);
    bit   full;
    int   l;
    exp_t x;
    if (&vv) begin
      while (recs.size() > 0 && recs[0].l + NN + 1 < t) void'(recs.pop_front());
      full = 1'b0;
      foreach (recs[i])
        if (recs[i].c < t && recs[i].l >= t && recs[i].l != recs[i].c) full = 1'b1;
      if (full) begin
        if (ovf_edge < 0) ovf_edge = t;
      end else begin
        l = t;
        if (recs.size() > 0 && recs[$].l + NN + 1 > t) l = recs[$].l + NN + 1;
        recs.push_back('{c: t, l: l});
        for (int k = 0; k < NN; k++) begin
          x.data   = d[k*DW +: DW];
          x.last   = (k == NN - 1);
          x.edge_n = l + 1 + k;
          sb.push_back(x);
        end
      end
    end else if (vv != '0) begin
      if (mis_edge < 0) mis_edge = t;
    end
  endtask

  task automatic drive(input logic [NN-1:0] vv, input logic [NN*DW-1:0] d);
    in_valid_vec = vv;
    in_data      = d;
    model_edge(edge_cnt + 1, vv, d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive('0, '0);
  endtask

  task automatic do_reset(input int n);
    rst          = 1'b1;
    in_valid_vec = '0;
    in_data      = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
      recs.delete();
      sb.delete();
      ovf_edge = -1;
      mis_edge = -1;
    end
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t x;
    int   e;
    if (check_en) begin
      e = edge_cnt;
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word: out_valid=1 data %0h after edge %0d, expected out_valid=0",
                   out_data, e);
        end else begin
          x = sb.pop_front();
          check("word_data", 64'(out_data), 64'(x.data));
          check("word_last", 64'(out_last), 64'(x.last));
          check("word_edge", 64'(e), 64'(x.edge_n));
        end
      end else begin
        check("idle_data", 64'(out_data), 64'd0);
        check("idle_last", 64'(out_last), 64'd0);
        if (sb.size() > 0 && sb[0].edge_n <= e) begin
          n_cmp++;
          n_fail++;
          $display("FAIL missing_word: out_valid=0 after edge %0d, expected word %0h",
                   e, sb[0].data);
          void'(sb.pop_front());
        end
      end
      check("busy", 64'(busy), 64'(exp_busy(e)));
      check("overflow", 64'(overflow), 64'(ovf_edge >= 0 && e >= ovf_edge));
      check("misalign", 64'(misalign), 64'(mis_edge >= 0 && e >= mis_edge));
    end
  end

  localparam logic [NN*DW-1:0] VEC_X = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
  localparam logic [NN*DW-1:0] VEC_A = {16'hFFFF, 16'h0001, 16'h8000, 16'h7FFF};
  localparam logic [NN*DW-1:0] VEC_B = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
  localparam logic [NN*DW-1:0] VEC_C = {16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D};

  initial begin
    logic [NN-1:0]    vv;
    logic [NN*DW-1:0] d;
    int               r;
    rst          = 1'b1;
    in_valid_vec = '0;
    in_data      = '0;
    do_reset(3);
    check_en = 1'b1;

    // single vector
    idle(3);
    drive('1, VEC_X);
    idle(8);
    // back-to-back with one pending
    drive('1, VEC_A);
    idle(1);
    drive('1, VEC_B);
    idle(10);
    // third vector dropped while pending is full
    drive('1, VEC_A);
    drive('1, VEC_B);
    drive('1, VEC_C);
    idle(12);
    do_reset(1);
    // second vector arrives on the edge of the last word
    drive('1, VEC_A);
    idle(3);
    drive('1, VEC_B);
    idle(10);
    // partial valid is ignored
    drive(4'b0101, VEC_C);
    idle(1);
    drive('1, VEC_A);
    idle(8);
    // reset mid-stream discards the pending vector
    drive('1, VEC_A);
    drive('1, VEC_B);
    idle(1);
    do_reset(1);
    idle(1);
    drive('1, VEC_C);
    idle(8);

    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(99));
      d = {$urandom, $urandom};
      if (r < 2) begin
        do_reset(1 + int'($urandom_range(1)));
      end else if (r < 40) begin
        drive('1, d);
      end else if (r < 48) begin
        vv = NN'($urandom_range(1, (1 << NN) - 2));
        drive(vv, d);
      end else begin
        drive('0, d);
      end
    end

    idle(20);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
